loop_nest_ctrl: RTL and testbench

LOOP_NEST_CTRL -- requirements
Module: loop_nest_ctrl

---
 rtl/loop_nest_pkg.sv | 12 +
 rtl/loop_nest_ctrl_level.sv | 55 +++++
 rtl/loop_nest_ctrl.sv | 132 +++++++++++++
 tb/tb_loop_nest_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_nest_pkg.sv
// Shared types and defaults for the three-level loop nest controller.
package loop_nest_pkg;

  localparam int W_DEFAULT = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : loop_nest_pkg

// File: rtl/loop_nest_ctrl_level.sv
// One loop level: latched bounds, index register, at-end compare and carry chain.
module loop_level
  import loop_nest_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] ini_i,
  input  logic [W-1:0] fin_i,
  input  logic         step_i,
  output logic [W-1:0] idx_o,
  output logic         at_end_o,
  output logic         carry_o
);

  logic [W-1:0] ini_q, ini_d;
  logic [W-1:0] fin_q, fin_d;
  logic [W-1:0] idx_q, idx_d;
  logic         at_end;

  // A reversed bound (fin < ini) behaves as a single iteration at ini.
  assign at_end = (idx_q == fin_q) | (fin_q < ini_q);

  always_comb begin
    ini_d = ini_q;
    fin_d = fin_q;
    idx_d = idx_q;
    if (load_i) begin
      ini_d = ini_i;
      fin_d = fin_i;
      idx_d = ini_i;
    end else if (step_i) begin
      idx_d = at_end ? ini_q : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ini_q <= '0;
      fin_q <= '0;
      idx_q <= '0;
    end else begin
      ini_q <= ini_d;
      fin_q <= fin_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o    = idx_q;
  assign at_end_o = at_end;
  assign carry_o  = step_i & at_end;

endmodule : loop_level

// File: rtl/loop_nest_ctrl.sv
// Three-level loop nest sequencer (level 0 innermost). Optional accumulator
// strobes acc_clr/acc_wr are compiled in only with LOOP_NEST_ACC_STROBE_EN.
//
// state  | meaning
// IDLE   | waiting for start; bounds latched when start arrives
// RUN    | one iteration per en-high cycle, indices live (valid=1)
// DONE   | single-cycle completion pulse, then back to IDLE
module loop_nest_ctrl
  import loop_nest_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [W-1:0] ini0,
  input  logic [W-1:0] fin0,
  input  logic [W-1:0] ini1,
  input  logic [W-1:0] fin1,
  input  logic [W-1:0] ini2,
  input  logic [W-1:0] fin2,
  output logic [W-1:0] idx0,
  output logic [W-1:0] idx1,
  output logic [W-1:0] idx2,
  output logic         valid,
  output logic         last0,
  output logic         last1,
  output logic         last2,
  output logic         busy,
  output logic         done,
  output logic         acc_clr,
  output logic         acc_wr
);

  state_e state_q, state_d;
  logic   load;
  logic   step0;
  logic   carry0, carry1, carry2;
  logic   end0, end1, end2;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step0   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step0 = en;
        // Carry out of the outermost level means every level wrapped to ini.
        if (carry2) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  loop_level #(.W(W)) u_level0 (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .ini_i    (ini0),
    .fin_i    (fin0),
    .step_i   (step0),
    .idx_o    (idx0),
    .at_end_o (end0),
    .carry_o  (carry0)
  );

  loop_level #(.W(W)) u_level1 (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .ini_i    (ini1),
    .fin_i    (fin1),
    .step_i   (carry0),
    .idx_o    (idx1),
    .at_end_o (end1),
    .carry_o  (carry1)
  );

  loop_level #(.W(W)) u_level2 (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .ini_i    (ini2),
    .fin_i    (fin2),
    .step_i   (carry1),
    .idx_o    (idx2),
    .at_end_o (end2),
    .carry_o  (carry2)
  );

  assign valid = (state_q == S_RUN);
  assign busy  = (state_q == S_RUN) | (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign last0 = end0 & valid;
  assign last1 = end1 & valid;
  assign last2 = end2 & valid;

`ifdef LOOP_NEST_ACC_STROBE_EN
  logic [W-1:0] acc_ini0_q, acc_ini0_d;

  // Private copy of ini0 so the level module stays free of strobe-only ports.
  always_comb begin
    acc_ini0_d = acc_ini0_q;
    if (load) acc_ini0_d = ini0;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_ini0_q <= '0;
    else     acc_ini0_q <= acc_ini0_d;
  end

  assign acc_clr = valid & (idx0 == acc_ini0_q);
  assign acc_wr  = valid & en & last0;
`else
  assign acc_clr = 1'b0;
  assign acc_wr  = 1'b0;
`endif

endmodule : loop_nest_ctrl

// File: tb/tb_loop_nest_ctrl.sv
// Self-checking bench for loop_nest_ctrl; expected iterations come from nested loops over the bounds.
module tb_loop_nest_ctrl;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst, start, en;
  logic [W-1:0] ini0, fin0, ini1, fin1, ini2, fin2;
  logic [W-1:0] idx0, idx1, idx2;
  logic         valid, last0, last1, last2, busy, done, acc_clr, acc_wr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a0, a1, a2;
    bit l0, l1, l2;
    bit first0;
  } iter_t;

  iter_t exp_q[$];

  always #5 clk = ~clk;

  loop_nest_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .ini0(ini0), .fin0(fin0), .ini1(ini1), .fin1(fin1), .ini2(ini2), .fin2(fin2),
    .idx0(idx0), .idx1(idx1), .idx2(idx2), .valid(valid),
    .last0(last0), .last1(last1), .last2(last2),
    .busy(busy), .done(done), .acc_clr(acc_clr), .acc_wr(acc_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int i0, f0, i1, f1, i2, f2);
    int e0, e1, e2;
    iter_t it;
    e0 = (f0 < i0) ? i0 : f0;
    e1 = (f1 < i1) ? i1 : f1;
    e2 = (f2 < i2) ? i2 : f2;
    exp_q.delete();
    for (int a2 = i2; a2 <= e2; a2++)
      for (int a1 = i1; a1 <= e1; a1++)
        for (int a0 = i0; a0 <= e0; a0++) begin
          it.a0 = a0; it.a1 = a1; it.a2 = a2;
          it.l0 = (a0 == e0); it.l1 = (a1 == e1); it.l2 = (a2 == e2);
          it.first0 = (a0 == i0);
          exp_q.push_back(it);
        end
  endtask

  // en_mode: 0 always high, 1 toggle 1,0,..., 2 random. mid_start re-issues start with other bounds.
  task automatic run_nest(input string name, input int i0, f0, i1, f1, i2, f2,
                          input int en_mode, input bit mid_start);
    int pos, cyc, dones, budget, vcyc;
    bit e, prev_final;
    bit exp_clr, exp_wr;
    build_exp(i0, f0, i1, f1, i2, f2);
    ini0 = W'(i0); fin0 = W'(f0); ini1 = W'(i1); fin1 = W'(f1); ini2 = W'(i2); fin2 = W'(f2);
    start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    pos = 0; cyc = 0; dones = 0; vcyc = 0; prev_final = 1'b0;
    budget = exp_q.size() * 4 + 20;
    while (cyc < budget) begin
      case (en_mode)
        0:       e = 1'b1;
        1:       e = (cyc % 2 == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      en = e;
      if (mid_start && pos == 3 && valid) begin
        start = 1'b1;
        ini0 = W'(i0 + 7); fin0 = W'(f0 + 9); ini1 = W'(i1 + 1); fin1 = W'(f1 + 4);
      end else begin
        start = 1'b0;
      end
      #1;
      if (valid) begin
        vcyc++;
        n_tests++;
        if (pos >= exp_q.size()) begin
          n_fail++;
          $display("FAIL %s overrun: got extra iteration idx=%0d,%0d,%0d, required only %0d iterations",
                   name, idx0, idx1, idx2, exp_q.size());
          break;
        end
        if (int'(idx0) !== exp_q[pos].a0 || int'(idx1) !== exp_q[pos].a1 ||
            int'(idx2) !== exp_q[pos].a2 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s idx@%0d: got %0d,%0d,%0d busy=%b required %0d,%0d,%0d busy=1",
                   name, pos, idx0, idx1, idx2, busy, exp_q[pos].a0, exp_q[pos].a1, exp_q[pos].a2);
        end
        n_tests++;
        if ({last2, last1, last0} !== {exp_q[pos].l2, exp_q[pos].l1, exp_q[pos].l0}) begin
          n_fail++;
          $display("FAIL %s last@%0d: got %b%b%b required %b%b%b", name, pos,
                   last2, last1, last0, exp_q[pos].l2, exp_q[pos].l1, exp_q[pos].l0);
        end
`ifdef LOOP_NEST_ACC_STROBE_EN
        exp_clr = exp_q[pos].first0;
        exp_wr  = e & exp_q[pos].l0;
`else
        exp_clr = 1'b0;
        exp_wr  = 1'b0;
`endif
        n_tests++;
        if (acc_clr !== exp_clr || acc_wr !== exp_wr) begin
          n_fail++;
          $display("FAIL %s acc@%0d: got clr=%b wr=%b required clr=%b wr=%b",
                   name, pos, acc_clr, acc_wr, exp_clr, exp_wr);
        end
        if (e) pos++;
        prev_final = e && (pos == exp_q.size());
      end else if (done) begin
        dones++;
        n_tests++;
        if (!prev_final || busy !== 1'b1 || acc_clr !== 1'b0 || acc_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_timing: got done after %0d/%0d iterations prev_final=%b busy=%b, required done right after final iteration with busy=1",
                   name, pos, exp_q.size(), prev_final, busy);
        end
        prev_final = 1'b0;
      end else if (!busy) begin
        break;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    n_tests++;
    if (cyc >= budget) begin
      n_fail++;
      $display("FAIL %s timeout: got no return to idle in %0d cycles, required completion", name, budget);
    end
    n_tests++;
    if (pos != exp_q.size() || dones != 1) begin
      n_fail++;
      $display("FAIL %s count: got %0d iterations %0d done pulses, required %0d iterations 1 done pulse",
               name, pos, dones, exp_q.size());
    end
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got valid=%b busy=%b done=%b, required all 0", name, valid, busy, done);
    end
    if (en_mode == 1) begin
      n_tests++;
      if (vcyc != 2 * exp_q.size() - 1) begin
        n_fail++;
        $display("FAIL %s toggle_cycles: got %0d run cycles, required %0d", name, vcyc, 2 * exp_q.size() - 1);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (idx0 !== '0 || idx1 !== '0 || idx2 !== '0 || valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || {last2, last1, last0} !== 3'b000 || acc_clr !== 1'b0 || acc_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got idx=%0d,%0d,%0d valid=%b busy=%b done=%b last=%b%b%b acc=%b%b, required all 0",
               name, idx0, idx1, idx2, valid, busy, done, last2, last1, last0, acc_clr, acc_wr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; en = 1'b1;
    ini0 = 12'd3; fin0 = 12'd5; ini1 = 12'd1; fin1 = 12'd2; ini2 = 12'd0; fin2 = 12'd1;
    tick(); tick();
    check_all_zero("reset_state");
    rst = 1'b0; start = 1'b0; en = 1'b0;
    tick();
    check_all_zero("reset_idle_hold");
  endtask

  task automatic test_basic();
    run_nest("basic_0_1_0_2_0_1", 0, 1, 0, 2, 0, 1, 0, 1'b0);
  endtask

  task automatic test_en_toggle();
    run_nest("en_toggle", 0, 1, 0, 2, 0, 1, 1, 1'b0);
  endtask

  task automatic test_reversed();
    run_nest("reversed_lvl1", 0, 1, 5, 3, 0, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    bit seen_done;
    ini0 = 12'd0; fin0 = 12'd1; ini1 = 12'd0; fin1 = 12'd2; ini2 = 12'd0; fin2 = 12'd1;
    start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if (valid !== 1'b1 || idx0 !== 12'd1 || idx1 !== 12'd1) begin
      n_fail++;
      $display("FAIL rst_mid_iter4: got valid=%b idx0=%0d idx1=%0d, required valid=1 idx0=1 idx1=1",
               valid, idx0, idx1);
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_all_zero("rst_mid_after");
    seen_done = 1'b0;
    for (k = 0; k < 4; k++) begin
      if (done || busy) seen_done = 1'b1;
      tick();
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: got done/busy after abandon, required none");
    end
    run_nest("rst_mid_restart", 0, 1, 0, 2, 0, 1, 0, 1'b0);
  endtask

  task automatic test_mid_start();
    run_nest("mid_start_ignored", 0, 1, 0, 2, 0, 1, 0, 1'b1);
  endtask

  task automatic test_acc_bounds();
    run_nest("acc_0_3_0_0_0_1", 0, 3, 0, 0, 0, 1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_nest("wrap_fin_max", 4094, 4095, 4095, 4095, 7, 8, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_nest("b2b_first", 2, 3, 1, 1, 4, 5, 0, 1'b0);
    run_nest("b2b_second", 0, 2, 3, 4, 0, 0, 2, 1'b0);
  endtask

  task automatic test_random();
    int b[6];
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 3; j++) begin
        b[2*j] = $urandom_range(0, 4095);
        if ($urandom_range(0, 5) == 0) b[2*j+1] = (b[2*j] == 0) ? 0 : b[2*j] - 1;
        else b[2*j+1] = (b[2*j] + $urandom_range(0, 3) > 4095) ? 4095 : b[2*j] + $urandom_range(0, 3);
      end
      run_nest($sformatf("random_%0d", r), b[0], b[1], b[2], b[3], b[4], b[5], 2, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0;
    ini0 = '0; fin0 = '0; ini1 = '0; fin1 = '0; ini2 = '0; fin2 = '0;
    test_reset();
    test_basic();
    test_en_toggle();
    test_reversed();
    test_reset_mid();
    test_mid_start();
    test_acc_bounds();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_loop_nest_ctrl
